// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one word-level memory port among three requesters.
// One whole transaction (request, plus read response) is in flight at a time.
//
// state    | meaning
// S_IDLE   | searching for a requester from the rotating pointer
// S_ISSUE  | captured request presented to memory
// S_WAIT   | read issued, waiting for memory data
// S_RETURN | read data presented to the owning requester
module mem_port_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_CLIENTS = 3
) (
  input  logic                  CLK,
  input  logic                  RST,

  input  logic                  C0_SEND_ADDR_VALID,
  input  logic [ADDR_WIDTH-1:0] C0_SEND_ADDR,
  input  logic                  C0_SEND_DATA_VALID,
  input  logic [DATA_WIDTH-1:0] C0_SEND_DATA,
  output logic                  C0_SEND_READY,
  output logic                  C0_RECEIVE_VALID,
  output logic [DATA_WIDTH-1:0] C0_RECEIVE_DATA,
  input  logic                  C0_RECEIVE_READY,

  input  logic                  C1_SEND_ADDR_VALID,
  input  logic [ADDR_WIDTH-1:0] C1_SEND_ADDR,
  input  logic                  C1_SEND_DATA_VALID,
  input  logic [DATA_WIDTH-1:0] C1_SEND_DATA,
  output logic                  C1_SEND_READY,
  output logic                  C1_RECEIVE_VALID,
  output logic [DATA_WIDTH-1:0] C1_RECEIVE_DATA,
  input  logic                  C1_RECEIVE_READY,

  input  logic                  C2_SEND_ADDR_VALID,
  input  logic [ADDR_WIDTH-1:0] C2_SEND_ADDR,
  input  logic                  C2_SEND_DATA_VALID,
  input  logic [DATA_WIDTH-1:0] C2_SEND_DATA,
  output logic                  C2_SEND_READY,
  output logic                  C2_RECEIVE_VALID,
  output logic [DATA_WIDTH-1:0] C2_RECEIVE_DATA,
  input  logic                  C2_RECEIVE_READY,

  output logic                  MEM_SEND_ADDR_VALID,
  output logic [ADDR_WIDTH-1:0] MEM_SEND_ADDR,
  output logic                  MEM_SEND_DATA_VALID,
  output logic [DATA_WIDTH-1:0] MEM_SEND_DATA,
  input  logic                  MEM_SEND_READY,
  input  logic                  MEM_RECEIVE_VALID,
  input  logic [DATA_WIDTH-1:0] MEM_RECEIVE_DATA,
  output logic                  MEM_RECEIVE_READY
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAIT   = 2'd2,
    S_RETURN = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [1:0]            r_ptr;
  logic [1:0]            r_owner;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_wr;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic                  w_req      [NUM_CLIENTS];
  logic                  w_rx_ready [NUM_CLIENTS];
  logic                  w_any;
  logic [1:0]            w_win;
  logic [1:0]            w_idx;
  logic [ADDR_WIDTH-1:0] w_win_addr;
  logic [DATA_WIDTH-1:0] w_win_data;
  logic                  w_win_wr;
  logic                  w_grant_en;
  logic                  w_accept;
  logic                  w_owner_ready;

  function automatic logic [1:0] f_next(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign w_req[0]      = C0_SEND_ADDR_VALID;
  assign w_req[1]      = C1_SEND_ADDR_VALID;
  assign w_req[2]      = C2_SEND_ADDR_VALID;
  assign w_rx_ready[0] = C0_RECEIVE_READY;
  assign w_rx_ready[1] = C1_RECEIVE_READY;
  assign w_rx_ready[2] = C2_RECEIVE_READY;

  // Search pointer, pointer+1, pointer+2 (mod 3); first valid requester wins.
  always_comb begin
    w_any = 1'b0;
    w_win = 2'd0;
    w_idx = r_ptr;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      if (!w_any && w_req[w_idx]) begin
        w_any = 1'b1;
        w_win = w_idx;
      end
      w_idx = f_next(w_idx);
    end
  end

  always_comb begin
    w_win_addr = C0_SEND_ADDR;
    w_win_data = C0_SEND_DATA;
    w_win_wr   = C0_SEND_DATA_VALID;
    case (w_win)
      2'd1: begin
        w_win_addr = C1_SEND_ADDR;
        w_win_data = C1_SEND_DATA;
        w_win_wr   = C1_SEND_DATA_VALID;
      end
      2'd2: begin
        w_win_addr = C2_SEND_ADDR;
        w_win_data = C2_SEND_DATA;
        w_win_wr   = C2_SEND_DATA_VALID;
      end
      default: ;
    endcase
  end

  // Reset holds the state at IDLE, so the grant is also masked by RST itself.
  assign w_grant_en    = (r_state == S_IDLE) && !RST;
  assign w_accept      = w_grant_en && w_any;
  assign w_owner_ready = (r_owner <= 2'd2) ? w_rx_ready[r_owner] : 1'b0;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_any) w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        if (MEM_SEND_READY) w_state_nxt = r_wr ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        if (MEM_RECEIVE_VALID) w_state_nxt = S_RETURN;
      end
      S_RETURN: begin
        if (w_owner_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_ptr   <= 2'd0;
      r_owner <= 2'd0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wr    <= 1'b0;
      r_rdata <= '0;
    end else begin
      if (r_state == S_IDLE && w_any) begin
        r_addr  <= w_win_addr;
        r_wdata <= w_win_data;
        r_wr    <= w_win_wr;
        r_owner <= w_win;
        r_ptr   <= f_next(w_win);
      end
      if (r_state == S_WAIT && MEM_RECEIVE_VALID) begin
        r_rdata <= MEM_RECEIVE_DATA;
      end
    end
  end

  assign C0_SEND_READY = w_accept && (w_win == 2'd0);
  assign C1_SEND_READY = w_accept && (w_win == 2'd1);
  assign C2_SEND_READY = w_accept && (w_win == 2'd2);

  // Read data is broadcast; only VALID is qualified by the owner.
  assign C0_RECEIVE_VALID = (r_state == S_RETURN) && (r_owner == 2'd0);
  assign C1_RECEIVE_VALID = (r_state == S_RETURN) && (r_owner == 2'd1);
  assign C2_RECEIVE_VALID = (r_state == S_RETURN) && (r_owner == 2'd2);
  assign C0_RECEIVE_DATA  = r_rdata;
  assign C1_RECEIVE_DATA  = r_rdata;
  assign C2_RECEIVE_DATA  = r_rdata;

  assign MEM_SEND_ADDR_VALID = (r_state == S_ISSUE);
  assign MEM_SEND_DATA_VALID = (r_state == S_ISSUE) && r_wr;
  assign MEM_SEND_ADDR       = r_addr;
  assign MEM_SEND_DATA       = r_wdata;
  assign MEM_RECEIVE_READY   = (r_state == S_WAIT);

endmodule
